// File: rtl/rf_wb_arbiter_if.sv
// Handshake and register-file bus for the write-back arbiter.
// Ports (as seen by the arbiter, slave modport):
//   A_Valid/A_Addr/A_Data -> A_Ready     ALU write-back request
//   B_Valid/B_Addr/B_Data -> B_Ready     load-unit write request
//   Claim_Valid/Claim_Addr               destination reservation from issue
//   Ard1/Ard2 -> Hazard1/Hazard2         read-after-write hazard lookup
//   Busy                                 pending-write scoreboard vector
//   Awr/Din/WrEn                         register file write port
interface rf_wb_arbiter_if;
    logic        A_Valid;
    logic [4:0]  A_Addr;
    logic [31:0] A_Data;
    logic        A_Ready;
    logic        B_Valid;
    logic [4:0]  B_Addr;
    logic [31:0] B_Data;
    logic        B_Ready;
    logic        Claim_Valid;
    logic [4:0]  Claim_Addr;
    logic [4:0]  Ard1;
    logic [4:0]  Ard2;
    logic        Hazard1;
    logic        Hazard2;
    logic [31:0] Busy;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn;

    modport slave (
        input  A_Valid, A_Addr, A_Data,
        output A_Ready,
        input  B_Valid, B_Addr, B_Data,
        output B_Ready,
        input  Claim_Valid, Claim_Addr, Ard1, Ard2,
        output Hazard1, Hazard2, Busy,
        output Awr, Din, WrEn
    );

    modport master (
        output A_Valid, A_Addr, A_Data,
        input  A_Ready,
        output B_Valid, B_Addr, B_Data,
        input  B_Ready,
        output Claim_Valid, Claim_Addr, Ard1, Ard2,
        input  Hazard1, Hazard2, Busy,
        input  Awr, Din, WrEn
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back controller for the 32x32 register file.
// Round-robin arbitration between the ALU (A) and load unit (B) for the
// single write port, plus a 32-entry pending-write scoreboard for hazards.
// Ports:
//   Clk    rising-edge clock shared with the register file
//   Rst_n  synchronous active-low reset
//   bus    rf_wb_arbiter_if.slave (requests, claims, hazards, write port)
//
// State  | meaning
// LAST_A | A won the most recent grant; B wins the next contention
// LAST_B | B won the most recent grant (reset value); A wins next
module rf_wb_arbiter (
    input  logic            Clk,
    input  logic            Rst_n,
    rf_wb_arbiter_if.slave  bus
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t       last_q, last_d;
    logic        grant_a, grant_b;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  awr_q, awr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] busy_q, busy_d;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        wr_en_d = 1'b0;
        awr_d   = awr_q;
        din_d   = din_q;
        busy_d  = busy_q;

        if (bus.A_Valid && (!bus.B_Valid || last_q == LAST_B)) begin
            grant_a = 1'b1;
        end else if (bus.B_Valid) begin
            grant_b = 1'b1;
        end

        if (grant_a) begin
            last_d  = LAST_A;
            awr_d   = bus.A_Addr;
            din_d   = bus.A_Data;
            wr_en_d = (bus.A_Addr != 5'd0);
        end else if (grant_b) begin
            last_d  = LAST_B;
            awr_d   = bus.B_Addr;
            din_d   = bus.B_Data;
            wr_en_d = (bus.B_Addr != 5'd0);
        end

        // Clear first so a claim on the same register in the same edge wins.
        if (wr_en_q) begin
            busy_d[awr_q] = 1'b0;
        end
        if (bus.Claim_Valid && bus.Claim_Addr != 5'd0) begin
            busy_d[bus.Claim_Addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            last_q  <= LAST_B;
            wr_en_q <= 1'b0;
            awr_q   <= 5'd0;
            din_q   <= 32'd0;
            busy_q  <= 32'd0;
        end else begin
            last_q  <= last_d;
            wr_en_q <= wr_en_d;
            awr_q   <= awr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.A_Ready = grant_a;
    assign bus.B_Ready = grant_b;
    assign bus.WrEn    = wr_en_q;
    assign bus.Awr     = awr_q;
    assign bus.Din     = din_q;
    assign bus.Busy    = busy_q;
    // No bypass: a hazard holds until the cycle after the write lands.
    assign bus.Hazard1 = busy_q[bus.Ard1];
    assign bus.Hazard2 = busy_q[bus.Ard2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   errors;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.A_Valid     = 1'b0;
        bus.A_Addr      = 5'd0;
        bus.A_Data      = 32'd0;
        bus.B_Valid     = 1'b0;
        bus.B_Addr      = 5'd0;
        bus.B_Data      = 32'd0;
        bus.Claim_Valid = 1'b0;
        bus.Claim_Addr  = 5'd0;
        bus.Ard1        = 5'd0;
        bus.Ard2        = 5'd0;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
    endtask

    logic [4:0]  exp_awr [4];
    logic [31:0] exp_din [4];
    logic        exp_ar  [4];
    int          ai, bi;

    initial begin
        checks = 0;
        errors = 0;
        Rst_n  = 1'b0;
        idle_inputs();
        step();
        step();
        Rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_wren",   {31'd0, bus.WrEn},    32'd0);
        check("rst_awr",    {27'd0, bus.Awr},     32'd0);
        check("rst_din",    bus.Din,              32'd0);
        check("rst_busy",   bus.Busy,             32'd0);
        check("rst_ardy",   {31'd0, bus.A_Ready}, 32'd0);
        check("rst_brdy",   {31'd0, bus.B_Ready}, 32'd0);
        check("rst_haz1",   {31'd0, bus.Hazard1}, 32'd0);
        check("rst_haz2",   {31'd0, bus.Hazard2}, 32'd0);

        // Single A write to r5
        bus.A_Valid = 1'b1;
        bus.A_Addr  = 5'd5;
        bus.A_Data  = 32'h1234_5678;
        #1;
        check("t1_ardy", {31'd0, bus.A_Ready}, 32'd1);
        check("t1_brdy", {31'd0, bus.B_Ready}, 32'd0);
        step();
        idle_inputs();
        #1;
        check("t1_wren", {31'd0, bus.WrEn}, 32'd1);
        check("t1_awr",  {27'd0, bus.Awr},  32'd5);
        check("t1_din",  bus.Din,           32'h1234_5678);
        step();
        check("t1_wren_off", {31'd0, bus.WrEn}, 32'd0);
        check("t1_awr_hold", {27'd0, bus.Awr},  32'd5);

        // Contention after reset: A first, then alternate
        do_reset();
        exp_awr[0] = 5'd1;  exp_din[0] = 32'hA000_0001; exp_ar[0] = 1'b1;
        exp_awr[1] = 5'd11; exp_din[1] = 32'hB000_000B; exp_ar[1] = 1'b0;
        exp_awr[2] = 5'd2;  exp_din[2] = 32'hA000_0002; exp_ar[2] = 1'b1;
        exp_awr[3] = 5'd12; exp_din[3] = 32'hB000_000C; exp_ar[3] = 1'b0;
        ai = 0;
        bi = 0;
        for (int c = 0; c < 4; c++) begin
            bus.A_Valid = 1'b1;
            bus.A_Addr  = 5'(1 + ai);
            bus.A_Data  = 32'hA000_0000 | (1 + ai);
            bus.B_Valid = 1'b1;
            bus.B_Addr  = 5'(11 + bi);
            bus.B_Data  = 32'hB000_0000 | (11 + bi);
            #1;
            check($sformatf("t2_ardy%0d", c), {31'd0, bus.A_Ready}, {31'd0, exp_ar[c]});
            check($sformatf("t2_brdy%0d", c), {31'd0, bus.B_Ready}, {31'd0, !exp_ar[c]});
            step();
            if (exp_ar[c]) ai++;
            else bi++;
            check($sformatf("t2_wren%0d", c), {31'd0, bus.WrEn}, 32'd1);
            check($sformatf("t2_awr%0d", c),  {27'd0, bus.Awr},  {27'd0, exp_awr[c]});
            check($sformatf("t2_din%0d", c),  bus.Din,           exp_din[c]);
        end
        idle_inputs();
        step();
        check("t2_wren_off", {31'd0, bus.WrEn}, 32'd0);

        // Claim r7, then B writes r7
        bus.Claim_Valid = 1'b1;
        bus.Claim_Addr  = 5'd7;
        step();
        bus.Claim_Valid = 1'b0;
        bus.Ard1 = 5'd7;
        bus.Ard2 = 5'd0;
        #1;
        check("t3_busy",  bus.Busy,              32'h0000_0080);
        check("t3_haz1",  {31'd0, bus.Hazard1},  32'd1);
        check("t3_haz2",  {31'd0, bus.Hazard2},  32'd0);
        bus.B_Valid = 1'b1;
        bus.B_Addr  = 5'd7;
        bus.B_Data  = 32'hDEAD_BEEF;
        #1;
        check("t3_brdy", {31'd0, bus.B_Ready}, 32'd1);
        step();
        bus.B_Valid = 1'b0;
        #1;
        check("t3_wren",      {31'd0, bus.WrEn},    32'd1);
        check("t3_awr",       {27'd0, bus.Awr},     32'd7);
        check("t3_din",       bus.Din,              32'hDEAD_BEEF);
        check("t3_busy_hold", bus.Busy,             32'h0000_0080);
        check("t3_haz1_hold", {31'd0, bus.Hazard1}, 32'd1);
        step();
        check("t3_busy_clr",  bus.Busy,             32'd0);
        check("t3_haz1_clr",  {31'd0, bus.Hazard1}, 32'd0);

        // Write to r0 and claim of r0
        bus.A_Valid = 1'b1;
        bus.A_Addr  = 5'd0;
        bus.A_Data  = 32'hFFFF_FFFF;
        #1;
        check("t5_ardy", {31'd0, bus.A_Ready}, 32'd1);
        step();
        bus.A_Valid     = 1'b0;
        bus.Claim_Valid = 1'b1;
        bus.Claim_Addr  = 5'd0;
        #1;
        check("t5_wren", {31'd0, bus.WrEn}, 32'd0);
        check("t5_din",  bus.Din,           32'hFFFF_FFFF);
        step();
        bus.Claim_Valid = 1'b0;
        #1;
        check("t5_busy", bus.Busy, 32'd0);

        // Claim r9 while a write to r9 lands on the same edge
        bus.Claim_Valid = 1'b1;
        bus.Claim_Addr  = 5'd9;
        step();
        bus.Claim_Valid = 1'b0;
        bus.A_Valid     = 1'b1;
        bus.A_Addr      = 5'd9;
        bus.A_Data      = 32'h0000_0909;
        step();
        bus.A_Valid     = 1'b0;
        bus.Claim_Valid = 1'b1;
        bus.Claim_Addr  = 5'd9;
        #1;
        check("t4_wren", {31'd0, bus.WrEn}, 32'd1);
        check("t4_awr",  {27'd0, bus.Awr},  32'd9);
        step();
        bus.Claim_Valid = 1'b0;
        bus.Ard2 = 5'd9;
        #1;
        check("t4_busy", bus.Busy,             32'h0000_0200);
        check("t4_haz2", {31'd0, bus.Hazard2}, 32'd1);

        // Claim r3 and r8, then reset during a pending write
        bus.Claim_Valid = 1'b1;
        bus.Claim_Addr  = 5'd3;
        step();
        bus.Claim_Addr  = 5'd8;
        step();
        bus.Claim_Valid = 1'b0;
        #1;
        check("t6_busy", bus.Busy, 32'h0000_0308);
        bus.A_Valid = 1'b1;
        bus.A_Addr  = 5'd20;
        bus.A_Data  = 32'h2020_2020;
        step();
        bus.A_Valid = 1'b0;
        bus.B_Valid = 1'b1;
        bus.B_Addr  = 5'd21;
        bus.B_Data  = 32'h2121_2121;
        Rst_n = 1'b0;
        #1;
        check("t6_wren_pend", {31'd0, bus.WrEn}, 32'd1);
        step();
        Rst_n = 1'b1;
        bus.B_Valid = 1'b0;
        #1;
        check("t6_wren", {31'd0, bus.WrEn}, 32'd0);
        check("t6_busy_rst", bus.Busy,      32'd0);
        check("t6_awr",  {27'd0, bus.Awr},  32'd0);
        check("t6_din",  bus.Din,           32'd0);
        bus.A_Valid = 1'b1;
        bus.A_Addr  = 5'd1;
        bus.A_Data  = 32'h0000_0001;
        bus.B_Valid = 1'b1;
        bus.B_Addr  = 5'd2;
        bus.B_Data  = 32'h0000_0002;
        #1;
        check("t6_ardy", {31'd0, bus.A_Ready}, 32'd1);
        check("t6_brdy", {31'd0, bus.B_Ready}, 32'd0);
        step();
        idle_inputs();
        #1;
        check("t6_awr_after", {27'd0, bus.Awr}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller for the 32x32 register file. Shares its single write port (Awr/Din/WrEn) between two requesters, the ALU write-back (A) and the load unit (B), using round-robin arbitration and valid/ready handshakes. Keeps a 32-entry pending-write scoreboard so issue logic can detect read-after-write hazards on the two read addresses. Sits between the execute/memory stages and the register file write port.

## Interface
- No parameters. Fixed widths: 5-bit register address, 32-bit data.
- Clk  in  1  rising-edge clock, shared with the register file
- Rst_n  in  1  synchronous active-low reset
- A_Valid  in  1  ALU write request
- A_Addr  in  5  ALU destination register
- A_Data  in  32  ALU result
- A_Ready  out  1  ALU request accepted this cycle
- B_Valid  in  1  load write request
- B_Addr  in  5  load destination register
- B_Data  in  32  load data
- B_Ready  out  1  load request accepted this cycle
- Claim_Valid  in  1  issue stage reserves a destination register
- Claim_Addr  in  5  reserved register
- Ard1, Ard2  in  5 each  read addresses being issued
- Hazard1, Hazard2  out  1 each  the corresponding read address is pending a write
- Busy  out  32  scoreboard vector; bit i set = write to register i outstanding
- Awr  out  5  to register file write address
- Din  out  32  to register file write data
- WrEn  out  1  to register file write enable

## Operation
- Reset (Rst_n low at a rising edge): WrEn=0, Awr=0, Din=0, Busy=0, last-grant pointer = B (so A wins the first contention). A_Ready, B_Ready and Hazard1/2 are combinational and evaluate to 0 while Busy=0 and no request is valid.
- Arbitration (combinational): only A_Valid -> grant A; only B_Valid -> grant B; both -> grant the side not granted last; neither -> no grant. A_Ready/B_Ready = grant to that side. The last-grant pointer updates only on an actual grant.
- Handshake: a transfer occurs when Valid && Ready at a rising edge. The requester holds Addr/Data stable until Ready. An ungranted request is not dropped and must be held.
- Write port: on a transfer, the next-cycle outputs are registered as Awr<=Addr, Din<=Data, WrEn<=(Addr!=0). Writes to r0 complete the handshake but never assert WrEn. With no transfer, WrEn<=0 and Awr/Din hold their values.
- Scoreboard, per edge:
  - A claim with Claim_Addr!=0 sets Busy[Claim_Addr].
  - A registered write (WrEn=1) clears Busy[Awr].
  - If the same register is both claimed and written in one edge, the bit ends set, because the new claim wins.
  - Claims to r0 are ignored, so Busy[0] is always 0.
- Hazard1 = Busy[Ard1] and Hazard2 = Busy[Ard2], both combinational with no bypass. A hazard deasserts in the cycle after the write lands.
- Writes to a register that was never claimed are legal and leave Busy unchanged (the bit was already 0).
- Back-to-back: one transfer per cycle maximum. Continuous contention alternates A,B,A,B.

## Timing
- Request-to-register-file latency: a transfer at edge N drives WrEn during cycle N+1, and the register file captures at edge N+1.
- Busy clears at edge N+1, the same edge the data lands. Hazard therefore drops in cycle N+2, when the new data is readable.
- Claim at edge M: Busy and Hazard are visible from cycle M+1.
- Reset asserted mid-operation: a pending WrEn is squashed at that edge, the scoreboard is cleared, and requester handshakes in that cycle are discarded (Ready is ignored while Rst_n=0).
- Throughput is 1 write per cycle.

## Test plan
- Reset, then A_Valid with A_Addr=5, A_Data=0x1234_5678 -> A_Ready=1 in the same cycle; next cycle WrEn=1, Awr=5, Din=0x12345678; the cycle after, WrEn=0.
- A and B both valid for 4 cycles, A to regs 1..4 and B to regs 11..14 -> write sequence is 1,11,2,12 on Awr. Each Ready pulses on alternate cycles, and each side holds its request while not ready.
- Claim reg 7 -> Busy[7]=1 next cycle and Hazard1=1 with Ard1=7. Then B writes reg 7 with 0xDEAD_BEEF -> Busy[7]=0 after the WrEn edge; Hazard1=0 in the following cycle.
- Claim reg 9 and have the pending write to reg 9 land on the same edge -> Busy[9] stays 1.
- A writes reg 0 with 0xFFFF_FFFF -> A_Ready=1 and WrEn stays 0. A claim of reg 0 -> Busy remains 0x0000_0000.
- Claim regs 3 and 8, then assert Rst_n=0 for one edge during an accepted write -> WrEn=0, Busy=0 and Awr=0 after reset, and the arbitration pointer favours A again.
